// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the unified-memory port arbiter: the FSM state
// encoding, the grant identifiers, default widths and the counter-width
// helper.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  localparam int DEF_MEM_LAT = 3;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  // ceil(log2(lat)) bits are enough to hold lat-1; never less than one bit.
  function automatic int cnt_width(input int lat);
    return (lat <= 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// -----------------------------------------------------------------------------
// lat_counter
// Loadable down-counter that times one memory access. Loading wins over
// decrementing; the count saturates at zero.
//   clk_i      : clock
//   rst_n_i    : asynchronous active-low reset
//   load_i     : load load_val_i into the counter
//   load_val_i : value loaded on load_i
//   dec_i      : decrement by one (ignored at zero)
//   cnt_o      : current count
//   zero_o     : count is zero
// -----------------------------------------------------------------------------
module lat_counter #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // NOTE: clocked state always uses non-blocking (<=) so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported, fixed-latency memory between instruction fetch
// (IF) and data access (MEM stage). One requester is granted at a time, the
// port is held stable for MEM_LAT cycles, then a one-cycle ready pulse is
// returned with registered read data. Simultaneous requests alternate,
// starting with data after reset.
//   clock, reset          : clock, asynchronous active-low reset
//   if_req/if_addr        : fetch request and PC
//   if_rdata/if_ready     : fetched instruction and its one-cycle valid pulse
//   dm_read/dm_write      : load / store request (both set = store)
//   dm_addr/dm_wdata      : data address and store data
//   dm_rdata/dm_ready     : load data and access-complete pulse
//   mem_en/mem_we         : memory port enable / write enable
//   mem_addr/mem_wdata    : latched address / write data
//   mem_rdata             : memory read data, valid in the last busy cycle
//   stall_if/stall_mem    : pipeline stalls for fetch / data access
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT = DEF_MEM_LAT,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int              CNT_W    = cnt_width(MEM_LAT);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);

  state_e            state_q, state_d;
  grant_e            last_grant_q;
  grant_e            gnt_d;
  logic              gnt_valid;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              busy;
  logic              cnt_zero;
  logic              dreq;
  logic [CNT_W-1:0]  cnt_unused;

  assign dreq = dm_read | dm_write;
  assign busy = (state_q == BUSY_I) || (state_q == BUSY_D);

  lat_counter #(.W(CNT_W)) u_lat_counter (
    .clk_i      (clock),
    .rst_n_i    (reset),
    .load_i     (gnt_valid),
    .load_val_i (LOAD_VAL),
    .dec_i      (busy),
    .cnt_o      (cnt_unused),
    .zero_o     (cnt_zero)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and arbitration.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch can never be inferred.
    state_d   = state_q;
    gnt_d     = GNT_I;
    gnt_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dreq && if_req) begin
          // Alternate on conflict: whoever did not win last time wins now.
          gnt_d     = (last_grant_q == GNT_D) ? GNT_I : GNT_D;
          gnt_valid = 1'b1;
        end else if (dreq) begin
          gnt_d     = GNT_D;
          gnt_valid = 1'b1;
        end else if (if_req) begin
          gnt_d     = GNT_I;
          gnt_valid = 1'b1;
        end
        if (gnt_valid) state_d = (gnt_d == GNT_D) ? BUSY_D : BUSY_I;
      end
      BUSY_I:  if (cnt_zero) state_d = DONE_I;
      BUSY_D:  if (cnt_zero) state_d = DONE_D;
      DONE_I,
      DONE_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch and read-data capture. Everything the memory sees is frozen
  // at grant, so requester inputs may change or drop while the access runs.
  // NOTE: these data registers are reset as well, so an access abandoned by
  // reset leaves no stale data visible afterwards.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant_q <= GNT_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      if (gnt_valid) begin
        last_grant_q <= gnt_d;
        if (gnt_d == GNT_D) begin
          addr_q  <= dm_addr;
          wdata_q <= dm_wdata;
          we_q    <= dm_write;
        end else begin
          addr_q <= if_addr;
          we_q   <= 1'b0;
        end
      end
      if ((state_q == BUSY_I) && cnt_zero) if_rdata_q <= mem_rdata;
      if ((state_q == BUSY_D) && cnt_zero && !we_q) dm_rdata_q <= mem_rdata;
    end
  end

  // Outputs.
  always_comb begin
    mem_en    = busy;
    mem_we    = busy & we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_ready  = (state_q == DONE_I);
    dm_ready  = (state_q == DONE_D);
    if_rdata  = if_rdata_q;
    dm_rdata  = dm_rdata_q;
    // Stalls are held low while reset is asserted.
    stall_if  = reset & if_req & ~if_ready;
    stall_mem = reset & dreq & ~dm_ready;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Scoreboarded bench: transactions are planned against a transaction-level
// model (who is served when, what the memory holds) and expected responses are
// queued; a negedge monitor compares every ready pulse, the port activity and
// the stalls against those expectations.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int L = 3;

  logic        clock;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;

  mem_port_arbiter #(.MEM_LAT(L), .ADDR_W(32), .DATA_W(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .dm_read   (dm_read),
    .dm_write  (dm_write),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { int cyc; logic [31:0] data; } rsp_t;
  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } port_t;

  rsp_t        if_q[$];
  rsp_t        dm_q[$];
  port_t       exp_port[int];
  logic [31:0] model_mem[logic [31:0]];
  logic [31:0] phys_mem[logic [31:0]];
  bit          model_last_d;
  logic [31:0] model_dm_rdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int run_cnt = 0;
  bit mon_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : init_val(a);
  endfunction

  function automatic void preload(input logic [31:0] a, input logic [31:0] d);
    model_mem[a] = d;
    phys_mem[a]  = d;
  endfunction

  // One access granted in IDLE cycle g: port busy g+1..g+L, ready at g+L+1.
  function automatic void plan(input bit is_d, input logic [31:0] a, input bit we,
                               input logic [31:0] wd, input int g);
    rsp_t r;
    for (int k = 1; k <= L; k++) exp_port[g + k] = '{addr: a, we: we, wdata: wd};
    r.cyc = g + L + 1;
    if (is_d) begin
      if (we) model_mem[a] = wd;
      else    model_dm_rdata = model_rd(a);
      r.data = model_dm_rdata;
      dm_q.push_back(r);
    end else begin
      r.data = model_rd(a);
      if_q.push_back(r);
    end
    model_last_d = is_d;
  endfunction

  // Behavioural memory: rdata is only meaningful in the last busy cycle,
  // writes commit at the end of the access.
  always @(posedge clock) begin
    cyc = cyc + 1;
    if (mem_en && mem_we && run_cnt == L - 1) phys_mem[mem_addr] = mem_wdata;
    run_cnt = mem_en ? run_cnt + 1 : 0;
  end

  always @(negedge clock) begin
    if (mem_en && run_cnt == L - 1) mem_rdata = phys_rd(mem_addr);
    else                            mem_rdata = 32'hBAD0_0000 | 32'(run_cnt);
  end

  // Monitor.
  always @(negedge clock) begin
    if (mon_en) begin
      logic  ri, rd, en_exp;
      port_t p;
      ri = (if_q.size() > 0) && (if_q[0].cyc == cyc);
      rd = (dm_q.size() > 0) && (dm_q[0].cyc == cyc);
      check("stall_if", stall_if, if_req & ~ri);
      check("stall_mem", stall_mem, (dm_read | dm_write) & ~rd);
      check("if_ready", if_ready, ri);
      check("dm_ready", dm_ready, rd);
      if (ri) begin
        check("if_rdata", if_rdata, if_q[0].data);
        void'(if_q.pop_front());
      end
      if (rd) begin
        check("dm_rdata", dm_rdata, dm_q[0].data);
        void'(dm_q.pop_front());
      end
      en_exp = exp_port.exists(cyc);
      check("mem_en", mem_en, en_exp);
      if (en_exp) begin
        p = exp_port[cyc];
        if (mem_en) begin
          check("mem_addr", mem_addr, p.addr);
          check("mem_we", mem_we, p.we);
          if (p.we) check("mem_wdata", mem_wdata, p.wdata);
        end
        exp_port.delete(cyc);
      end
    end
  end

  task automatic txn(input bit do_i, input bit do_rd, input bit do_wr,
                     input logic [31:0] ia, input logic [31:0] da,
                     input logic [31:0] wd, input bit scramble);
    int c, n;
    bit dreq, first_d, pend_i, pend_d, dn_i, dn_d;
    @(posedge clock); #1;
    c = cyc;
    dreq = do_rd | do_wr;
    if_req = do_i; if_addr = ia;
    dm_read = do_rd; dm_write = do_wr; dm_addr = da; dm_wdata = wd;
    if (do_i && dreq) begin
      first_d = !model_last_d;
      if (first_d) begin
        plan(1, da, do_wr, wd, c);
        plan(0, ia, 0, wd, c + L + 2);
      end else begin
        plan(0, ia, 0, wd, c);
        plan(1, da, do_wr, wd, c + L + 2);
      end
    end else if (do_i) begin
      plan(0, ia, 0, wd, c);
    end else if (dreq) begin
      plan(1, da, do_wr, wd, c);
    end
    pend_i = do_i; pend_d = dreq; n = 0;
    while ((pend_i || pend_d) && n < 2 * L + 10) begin
      @(posedge clock); #1;
      n++;
      if (!do_i) if_addr = $urandom;
      if (!dreq) begin dm_addr = $urandom; dm_wdata = $urandom; end
      if (scramble) begin
        if (do_i) begin
          if_addr = $urandom;
          if ($urandom_range(0, 3) == 0) if_req = 1'b0;
        end else begin
          dm_addr = $urandom; dm_wdata = $urandom;
          if ($urandom_range(0, 3) == 0) begin dm_read = 1'b0; dm_write = 1'b0; end
        end
      end
      dn_i = pend_i && if_ready;
      dn_d = pend_d && dm_ready;
      if (dn_i) pend_i = 0;
      if (dn_d) pend_d = 0;
      if (dn_i || dn_d) begin
        @(negedge clock); #1;
        if (dn_i) if_req = 1'b0;
        if (dn_d) begin dm_read = 1'b0; dm_write = 1'b0; end
      end
    end
    check("txn_pending", {30'd0, pend_i, pend_d}, 32'd0);
    if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0;
  endtask

  initial begin
    int c, kind;
    logic [31:0] a1, a2, w;
    reset = 1'b0;
    if_req = 1'b1; dm_read = 1'b1; dm_write = 1'b0;
    if_addr = 32'h0040_0000; dm_addr = 32'h1001_0000; dm_wdata = 32'h1;
    mem_rdata = '0;
    model_last_d = 0; model_dm_rdata = '0;
    #3;
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_if_ready", if_ready, 0);
    check("rst_dm_ready", dm_ready, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    check("rst_stall_if", stall_if, 0);
    check("rst_stall_mem", stall_mem, 0);
    if_req = 1'b0; dm_read = 1'b0;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1; mon_en = 1;

    // Conflict straight out of reset: data first, then fetch.
    preload(32'h1001_0000, 32'hDEAD_BEEF);
    preload(32'h0040_0000, 32'h2008_0005);
    txn(1, 1, 0, 32'h0040_0000, 32'h1001_0000, 32'h0, 0);
    // Fetch only.
    txn(1, 0, 0, 32'h0040_0000, 32'h0, 32'h0, 0);
    // Store: dm_rdata keeps the earlier load value.
    txn(0, 0, 1, 32'h0, 32'h1001_0004, 32'h0000_1234, 0);
    // Read and write together behave as a write.
    txn(0, 1, 1, 32'h0, 32'h1001_0008, 32'hCAFE_0001, 0);
    // Read back both stores.
    txn(0, 1, 0, 32'h0, 32'h1001_0004, 32'h0, 0);
    txn(1, 0, 0, 32'h1001_0008, 32'h0, 32'h0, 1);

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 4);
      a1 = 32'h1000_0000 + 32'(4 * $urandom_range(0, 7));
      a2 = 32'h1000_0000 + 32'(4 * $urandom_range(0, 7));
      w  = $urandom;
      case (kind)
        0: txn(1, 0, 0, a1, a2, w, $urandom_range(0, 1) == 1);
        1: txn(0, 1, 0, a1, a2, w, $urandom_range(0, 1) == 1);
        2: txn(0, 0, 1, a1, a2, w, $urandom_range(0, 1) == 1);
        3: txn(0, 1, 1, a1, a2, w, $urandom_range(0, 1) == 1);
        default: begin
          if ($urandom_range(0, 1) == 1) txn(1, 1, 0, a1, a2, w, 0);
          else                           txn(1, 0, 1, a1, a2, w, 0);
        end
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clock);
    end

    // Reset in the second busy cycle of a load.
    @(posedge clock); #1;
    c = cyc;
    dm_read = 1'b1; dm_addr = 32'h1001_0000;
    plan(1, 32'h1001_0000, 0, 32'h0, c);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0; mon_en = 0;
    #1;
    check("mid_rst_mem_en", mem_en, 0);
    check("mid_rst_dm_ready", dm_ready, 0);
    check("mid_rst_dm_rdata", dm_rdata, 0);
    check("mid_rst_if_rdata", if_rdata, 0);
    check("mid_rst_stall_mem", stall_mem, 0);
    if_q.delete(); dm_q.delete(); exp_port.delete();
    model_last_d = 0; model_dm_rdata = '0;
    repeat (2) begin
      @(negedge clock);
      check("in_rst_dm_ready", dm_ready, 0);
      check("in_rst_mem_en", mem_en, 0);
    end
    dm_read = 1'b0;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1; mon_en = 1;
    txn(1, 0, 0, 32'h0040_0000, 32'h0, 32'h0, 0);
    @(posedge clock); #1;
    check("final_if_q_empty", if_q.size(), 0);
    check("final_dm_q_empty", dm_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
